bar_drain: RTL and testbench

BAR_DRAIN -- requirements
Module: bar_drain

---
 rtl/bar_drain.sv | 114 +++++++++++
 tb/tb_bar_drain.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bar_drain.sv
// Thermometer LED bar that drains one step per TICK_DIV cycles while btn is held.
// Optional refill-on-release is enabled by defining BAR_REFILL_EN.
module bar_drain #(
  parameter int unsigned TICK_DIV = 6250000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        btn,
  output logic [15:0] led,
  output logic [4:0]  level,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [4:0]    level_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          start_q;
  logic          arm_ok;
  logic          arm;
  logic          tick;

  function automatic logic [15:0] thermo(input logic [4:0] lvl);
    logic [15:0] t;
    t = '0;
    for (int i = 0; i < 16; i++) t[i] = (5'(i) < lvl);
    return t;
  endfunction

  // arm_ok blocks a start held high across reset release from looking like an edge
  assign arm  = start & ~start_q & arm_ok;
  assign tick = (cnt == TICK_LAST);

  always_comb begin
    state_n = state;
    level_n = level;
    cnt_n   = cnt;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          state_n = DRAIN;
          level_n = 5'd16;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (btn) begin
          if (tick) begin
            cnt_n = '0;
            if (level != 5'd0) level_n = level - 5'd1;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end else if (level == 5'd0) begin
          state_n = DONE;
          cnt_n   = '0;
        end else begin
`ifdef BAR_REFILL_EN
          if (level != 5'd16) begin
            if (tick) begin
              cnt_n   = '0;
              level_n = level + 5'd1;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else begin
            cnt_n = '0;
          end
`else
          cnt_n = '0;
`endif
        end
      end
      default: begin
        state_n = IDLE;
        level_n = 5'd0;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      level   <= 5'd0;
      led     <= 16'h0000;
      busy    <= 1'b0;
      done    <= 1'b0;
      start_q <= 1'b0;
      arm_ok  <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_n;
      level   <= level_n;
      led     <= thermo(level_n);
      busy    <= (state_n == DRAIN);
      done    <= (state_n == DONE);
      start_q <= start;
      if (!start) arm_ok <= 1'b1;
      cnt     <= cnt_n;
    end
  end

endmodule

// File: tb/tb_bar_drain.sv
// Bench for bar_drain at TICK_DIV=4: vector table, hand corner sequences, random vs model.
module tb_bar_drain;
  localparam int TD = 4;
`ifdef BAR_REFILL_EN
  localparam bit REFILL = 1'b1;
`else
  localparam bit REFILL = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        btn = 1'b0;
  logic [15:0] led;
  logic [4:0]  level;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  // model: phase 0=idle 1=drain 2=done; run counts consecutive active counter cycles
  int m_phase, m_lvl, m_run, m_last;

  typedef struct {
    bit st;
    bit bt;
    int n;
    int lvl;
    int ld;
    bit bsy;
    bit dn;
  } vec_t;
  vec_t tbl[14];

  bar_drain #(.TICK_DIV(TD)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .btn(btn),
    .led(led), .level(level), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_phase = 0; m_lvl = 0; m_run = 0; m_last = -1;
  endtask

  task automatic model_edge();
    bit edge_seen;
    if (!reset_n) return;
    edge_seen = start && (m_last == 0);
    m_last = start;
    if (m_phase != 1) begin
      if (edge_seen) begin m_phase = 1; m_lvl = 16; m_run = 0; end
    end else if (btn) begin
      m_run++;
      if (m_run == TD) begin m_run = 0; if (m_lvl > 0) m_lvl--; end
    end else if (m_lvl == 0) begin
      m_phase = 2; m_run = 0;
    end else if (REFILL && m_lvl < 16) begin
      m_run++;
      if (m_run == TD) begin m_run = 0; m_lvl++; end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int lv, input int ld, input int bs, input int dn);
    chk({tag, ".level"}, int'(level), lv);
    chk({tag, ".led"}, int'(led), ld);
    chk({tag, ".busy"}, int'(busy), bs);
    chk({tag, ".done"}, int'(done), dn);
  endtask

  task automatic chk_model(input string tag);
    chk_all(tag, m_lvl, (1 << m_lvl) - 1, int'(m_phase == 1), int'(m_phase == 2));
  endtask

  initial begin
    int run_left;
    int rl;
    model_reset();
    #1;
    chk_all("reset0", 0, 0, 0, 0);
    step();
    step();
    reset_n = 1'b1;

    rl = REFILL ? 16 : 11;
    tbl[0]  = '{0, 0,   2,  0, 16'h0000, 0, 0};
    tbl[1]  = '{1, 0,   1, 16, 16'hFFFF, 1, 0};
    tbl[2]  = '{1, 1,  20, 11, 16'h07FF, 1, 0};
    tbl[3]  = '{0, 0, 100, rl, (1 << rl) - 1, 1, 0};
    tbl[4]  = '{0, 1,  64,  0, 16'h0000, 1, 0};
    tbl[5]  = '{0, 1,  40,  0, 16'h0000, 1, 0};
    tbl[6]  = '{0, 0,   1,  0, 16'h0000, 0, 1};
    tbl[7]  = '{0, 0,   5,  0, 16'h0000, 0, 1};
    tbl[8]  = '{1, 0,   1, 16, 16'hFFFF, 1, 0};
    tbl[9]  = '{0, 0,   1, 16, 16'hFFFF, 1, 0};
    tbl[10] = '{1, 0,   1, 16, 16'hFFFF, 1, 0};
    tbl[11] = '{1, 1,  63,  1, 16'h0001, 1, 0};
    tbl[12] = '{1, 1,   1,  0, 16'h0000, 1, 0};
    tbl[13] = '{0, 0,   1,  0, 16'h0000, 0, 1};

    foreach (tbl[i]) begin
      start = tbl[i].st;
      btn   = tbl[i].bt;
      repeat (tbl[i].n) step();
      chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].ld, tbl[i].bsy, tbl[i].dn);
      chk_model($sformatf("vec%0d.model", i));
    end

    // first decrement lands exactly TICK_DIV cycles after btn goes high
    start = 1'b1; btn = 1'b0;
    step();
    chk_all("rearm", 16, 16'hFFFF, 1, 0);
    btn = 1'b1;
    repeat (TD - 1) step();
    chk("first_tick.before", int'(level), 16);
    step();
    chk("first_tick.at", int'(level), 15);
    repeat (6 * TD) step();
    chk_all("lvl9", 9, 16'h01FF, 1, 0);

    // async reset between edges, start held high through release
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    btn = 1'b0;
    step();
    step();
    #2;
    reset_n = 1'b1;
    repeat (3) step();
    chk_all("held_start", 0, 0, 0, 0);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    chk_all("fresh_arm", 16, 16'hFFFF, 1, 0);
    chk_model("fresh_arm.model");

    run_left = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_model("rnd_rst");
        step();
        reset_n = 1'b1;
      end
      if ($urandom_range(0, 19) == 0) start = ~start;
      if (run_left == 0) begin
        btn = ($urandom_range(0, 3) != 0);
        run_left = $urandom_range(1, 30);
      end
      run_left--;
      step();
      chk_model($sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
